// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for an NCO: steps the phase increment from f_start by f_step,
// holding each frequency for a programmable dwell, with optional looping and abort.
module nco_sweep_ctrl #(
  parameter int APR = 32,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           stop,
  input  logic           loop,
  input  logic [APR-1:0] f_start,
  input  logic [APR-1:0] f_step,
  input  logic [CW-1:0]  n_steps,
  input  logic [CW-1:0]  dwell,
  input  logic           nco_valid,
  output logic [APR-1:0] phi_inc_o,
  output logic           nco_clken,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  step_idx
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DWELL  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]     state;
  logic [CW-1:0]  dwell_cnt;
  logic [APR-1:0] f_start_s;
  logic [APR-1:0] f_step_s;
  logic [CW-1:0]  last_idx_s;
  logic [CW-1:0]  dwell_s;
  logic           loop_s;

  function automatic logic [CW-1:0] at_least_one(input logic [CW-1:0] v);
    return (v == '0) ? CW'(1) : v;
  endfunction

  // Two's-complement f_step makes plain unsigned addition sweep both ways and wrap mod 2^APR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phi_inc_o  <= '0;
      step_idx   <= '0;
      dwell_cnt  <= '0;
      nco_clken  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      f_start_s  <= '0;
      f_step_s   <= '0;
      last_idx_s <= '0;
      dwell_s    <= '0;
      loop_s     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && state != IDLE) begin
        state     <= IDLE;
        busy      <= 1'b0;
        nco_clken <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              f_start_s  <= f_start;
              f_step_s   <= f_step;
              last_idx_s <= at_least_one(n_steps) - CW'(1);
              dwell_s    <= at_least_one(dwell);
              loop_s     <= loop;
              phi_inc_o  <= f_start;
              step_idx   <= '0;
              state      <= SETTLE;
              busy       <= 1'b1;
              nco_clken  <= 1'b1;
            end
          end
          SETTLE: begin
            if (nco_valid) begin
              dwell_cnt <= dwell_s;
              state     <= DWELL;
            end
          end
          DWELL: begin
            dwell_cnt <= dwell_cnt - CW'(1);
            if (dwell_cnt == CW'(1)) begin
              if (step_idx != last_idx_s) begin
                phi_inc_o <= phi_inc_o + f_step_s;
                step_idx  <= step_idx + CW'(1);
                dwell_cnt <= dwell_s;
              end else if (loop_s) begin
                phi_inc_o <= f_start_s;
                step_idx  <= '0;
                dwell_cnt <= dwell_s;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            nco_clken <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed scenarios plus randomized sweeps checked cycle by cycle
// against an expected output trace derived from the sweep rules.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [31:0] f_start = '0;
  logic [31:0] f_step = '0;
  logic [15:0] n_steps = '0;
  logic [15:0] dwell = '0;
  logic        nco_valid = 1'b0;
  logic [31:0] phi_inc_o;
  logic        nco_clken;
  logic        busy;
  logic        done;
  logic [15:0] step_idx;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] phi;
    logic [15:0] idx;
    logic        busy;
    logic        clken;
    logic        done;
  } exp_t;

  exp_t exp_q[$];

  nco_sweep_ctrl #(.APR(32), .CW(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop(loop),
    .f_start(f_start), .f_step(f_step), .n_steps(n_steps), .dwell(dwell),
    .nco_valid(nco_valid), .phi_inc_o(phi_inc_o), .nco_clken(nco_clken),
    .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  // Expected outputs per cycle after the start edge: settle, every frequency for its dwell
  // (repeating when looping), a single done cycle, then idle holding the final values.
  task automatic build_trace(input logic [31:0] fs, input logic [31:0] fst, input int n, input int d,
                             input logic lp, input int settle_k, input int stop_at, input int ncycles);
    int nn;
    int dd;
    logic [31:0] p;
    exp_t e;
    nn = (n == 0) ? 1 : n;
    dd = (d == 0) ? 1 : d;
    exp_q.delete();
    for (int i = 0; i <= settle_k; i++) exp_q.push_back('{fs, 16'd0, 1'b1, 1'b1, 1'b0});
    while (exp_q.size() < ncycles) begin
      for (int i = 0; i < nn; i++) begin
        p = fs + fst * 32'(i);
        for (int j = 0; j < dd; j++) exp_q.push_back('{p, 16'(i), 1'b1, 1'b1, 1'b0});
      end
      if (!lp) begin
        p = fs + fst * 32'(nn - 1);
        exp_q.push_back('{p, 16'(nn - 1), 1'b1, 1'b1, 1'b1});
        while (exp_q.size() < ncycles) exp_q.push_back('{p, 16'(nn - 1), 1'b0, 1'b0, 1'b0});
      end
    end
    if (stop_at >= 0) begin
      e = exp_q[stop_at];
      for (int c = stop_at + 1; c < ncycles; c++) exp_q[c] = '{e.phi, e.idx, 1'b0, 1'b0, 1'b0};
    end
  endtask

  task automatic run_sweep(input string name, input logic [31:0] fs, input logic [31:0] fst,
                           input int n, input int d, input logic lp, input int settle_k,
                           input int stop_at_in, input int ncycles, input bit noisy);
    int stop_at;
    int done_seen;
    int done_exp;
    exp_t e;
    stop_at = stop_at_in;
    if (lp && stop_at < 0) stop_at = ncycles - 2;
    build_trace(fs, fst, n, d, lp, settle_k, stop_at, ncycles);
    @(negedge clk);
    f_start = fs; f_step = fst; n_steps = 16'(n); dwell = 16'(d); loop = lp;
    start = 1'b1; stop = 1'b0; nco_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    done_seen = 0;
    done_exp = 0;
    for (int c = 0; c < ncycles; c++) begin
      e = exp_q[c];
      done_exp += int'(e.done);
      done_seen += int'(done === 1'b1);
      n_checks++;
      if ({phi_inc_o, step_idx, busy, nco_clken, done} !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got phi=%h idx=%0d busy=%b clken=%b done=%b, want phi=%h idx=%0d busy=%b clken=%b done=%b",
                 name, c, phi_inc_o, step_idx, busy, nco_clken, done, e.phi, e.idx, e.busy, e.clken, e.done);
      end
      nco_valid = (c >= settle_k);
      stop = (c == stop_at);
      start = noisy && e.busy;
      if (noisy) begin
        f_start = $urandom; f_step = $urandom; loop = 1'($urandom);
        n_steps = 16'($urandom_range(0, 7)); dwell = 16'($urandom_range(0, 7));
      end
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0;
    n_checks++;
    if (done_seen != done_exp) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d, want %0d", name, done_seen, done_exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({phi_inc_o, step_idx, busy, nco_clken, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got phi=%h idx=%0d busy=%b clken=%b done=%b, want all 0",
               phi_inc_o, step_idx, busy, nco_clken, done);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, nco_clken, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b clken=%b done=%b, want 000", busy, nco_clken, done);
    end
  endtask

  task automatic test_basic_sweep();
    run_sweep("basic", 32'h1000_0000, 32'h0100_0000, 3, 4, 1'b0, 0, -1, 18, 1'b0);
  endtask

  task automatic test_settle_holdoff();
    run_sweep("settle", 32'h2345_0000, 32'hFFFF_0000, 2, 3, 1'b0, 10, -1, 22, 1'b0);
  endtask

  task automatic test_wrap_loop();
    run_sweep("wrap_loop", 32'hFFFF_FFF0, 32'h0000_0020, 2, 1, 1'b1, 0, -1, 12, 1'b0);
  endtask

  task automatic test_abort();
    run_sweep("abort", 32'h1000_0000, 32'h0100_0000, 3, 4, 1'b0, 0, 6, 12, 1'b0);
  endtask

  task automatic test_zero_config();
    run_sweep("zero_cfg", 32'h0ABC_DEF0, 32'h1111_1111, 0, 0, 1'b0, 0, -1, 6, 1'b1);
  endtask

  task automatic test_collision();
    logic [31:0] phi_before;
    logic [15:0] idx_before;
    @(negedge clk);
    phi_before = phi_inc_o;
    idx_before = step_idx;
    f_start = 32'h5555_5555; n_steps = 16'd2; dwell = 16'd2;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    n_checks++;
    if ({busy, nco_clken, done, phi_inc_o, step_idx} !== {3'b000, phi_before, idx_before}) begin
      n_fail++;
      $display("FAIL start_stop_idle: got busy=%b clken=%b done=%b phi=%h idx=%0d, want 000 phi=%h idx=%0d",
               busy, nco_clken, done, phi_inc_o, step_idx, phi_before, idx_before);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_idle_hold: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    f_start = 32'h3000_0000; f_step = 32'h10; n_steps = 16'd4; dwell = 16'd5; loop = 1'b0;
    start = 1'b1; nco_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({phi_inc_o, step_idx, busy, nco_clken, done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_clear: got phi=%h idx=%0d busy=%b clken=%b done=%b, want all 0",
               phi_inc_o, step_idx, busy, nco_clken, done);
    end
    #1 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({phi_inc_o, step_idx, busy, nco_clken, done} !== '0) begin
        n_fail++;
        $display("FAIL async_reset_idle: got phi=%h idx=%0d busy=%b clken=%b done=%b, want all 0",
                 phi_inc_o, step_idx, busy, nco_clken, done);
      end
    end
  endtask

  task automatic test_random();
    int n;
    int d;
    int settle_k;
    int stop_at;
    logic lp;
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(0, 4);
      d = $urandom_range(0, 4);
      settle_k = $urandom_range(0, 3);
      lp = 1'($urandom);
      stop_at = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 23)) : -1;
      run_sweep("random", $urandom, $urandom, n, d, lp, settle_k, stop_at, 26, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_settle_holdoff();
    test_wrap_loop();
    test_abort();
    test_zero_config();
    test_collision();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
